cia_todgen: RTL and testbench
=============================

CIA_TODGEN -- requirements
Module: cia_todgen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter CLK_HZ, default 24000000, SHALL give the clk frequency in Hz.
REQ-003 Parameter LOCK_EDGES, default 4, SHALL give the number of consecutive in-window external edges required to lock.
REQ-004 clk  input  1  system clock; all logic is on its rising edge.
REQ-005 res_n  input  1  synchronous active-low reset.
REQ-006 en  input  1  generator enable.
REQ-007 sel60  input  1  selects mains rate: 1 = 60 Hz, 0 = 50 Hz.
REQ-008 ext_tod  input  1  external mains-derived TOD square wave, asynchronous; used only when CIA_TODGEN_SYNC_EN is defined.
REQ-009 tod_o  output  1  square wave driving the CIA TOD pin.
REQ-010 tick  output  1  one-clk strobe coincident with each 0->1 transition of tod_o.
REQ-011 ext_lock  output  1  high while tod_o is sourced from ext_tod; constant 0 without CIA_TODGEN_SYNC_EN.

Function
REQ-012 The internal generator SHALL use a phase accumulator of width clog2(CLK_HZ)+1.
- Each clk with en=1, add INC = 2*F, where F = 60 or 50 per sel60.
- If the sum is >= CLK_HZ, subtract CLK_HZ in the same cycle and toggle the internal wave.
REQ-013 The average internal frequency SHALL be exactly F with zero long-term drift; instantaneous half-period jitter SHALL be at most 1 clk.
REQ-014 A change of sel60 SHALL take effect on the next accumulation without resetting the accumulator or the output level.
REQ-015 With en=0, the accumulator and tod_o SHALL hold, tick SHALL be 0, and sync state SHALL reset to INT.
REQ-016 tick SHALL be registered and asserted in the same cycle that tod_o first reads 1; no tick on a 1->0 transition.
REQ-017 Sync state machine, compiled only with CIA_TODGEN_SYNC_EN; states INT, ACQ, EXT:
- ext_tod passes through a 2-flop synchronizer followed by a rising-edge detector.
- An interval counter counts clk cycles between detected edges.
- Valid window: CLK_HZ/F +/- 12.5%, computed with the current sel60.
REQ-018 INT->ACQ SHALL occur on any detected edge; the interval counter clears.
REQ-019 In ACQ, each in-window edge SHALL increment the lock count and an out-of-window edge SHALL restart ACQ with count 0.
- ACQ->INT occurs when the interval counter exceeds the window maximum.
- ACQ->EXT occurs on the edge that makes the count equal LOCK_EDGES.
REQ-020 In EXT, tod_o SHALL equal the synchronized ext_tod (latency 2 clk from ext_tod), and tick SHALL follow its rising edges.
REQ-021 EXT->INT SHALL occur when the interval counter exceeds 2.5*CLK_HZ/F.
- tod_o holds its level at the switch.
- The accumulator restarts from 0, so the next toggle comes one half-period later.
REQ-022 An out-of-window edge in EXT SHALL NOT drop lock; only the timeout drops it.
REQ-023 In INT and ACQ, tod_o SHALL come from the internal generator; switching source SHALL produce no pulse shorter than one clk.
REQ-024 The interval counter SHALL saturate rather than wrap.

Reset
REQ-025 While res_n=0 at a clk edge, the block SHALL set:
- tod_o = 0, tick = 0, ext_lock = 0;
- accumulator = 0, state = INT, lock count = 0, interval counter = 0;
- synchronizer flops = 0.
REQ-026 Reset asserted mid-operation SHALL take effect on that edge regardless of en or state.

Configuration
REQ-027 With macro CIA_TODGEN_SYNC_EN defined, ext_tod, the synchronizer and the sync state machine SHALL be built as specified.
REQ-028 Without CIA_TODGEN_SYNC_EN, ext_tod SHALL be ignored, ext_lock SHALL be tied to 0, and tod_o SHALL always come from the internal generator.

Structure
REQ-029 The cia package SHALL hold:
- the sync state enum type todgen_state_t;
- constants TOD_HZ_50 = 50 and TOD_HZ_60 = 60.
REQ-030 The phase accumulator SHALL be a sub-module, cia_phase_acc, parameterized by CLK_HZ, with enable, increment and toggle-strobe ports; the sync state machine SHALL stay in cia_todgen.

Verification (bench uses CLK_HZ=1200)
REQ-031 Verification SHALL cover these scenarios:
- sel60=1, en=1, 100 periods -> tod_o toggles every 10 clk, period 20 clk, exactly one tick per period.
- sel60=0 -> toggles every 12 clk; switching sel60 mid-period changes the toggle spacing with no reset of level.
- res_n=0 held 1 clk mid-high-phase -> next cycle tod_o=0, tick=0, ext_lock=0; restart gives first toggle after 10 clk (sel60=1).
- SYNC_EN, sel60=1, ext_tod period 20 clk -> ext_lock=1 on the 4th in-window edge, and tod_o tracks ext_tod with 2 clk latency.
- SYNC_EN, locked, then ext_tod stuck -> ext_lock=0 after 50 clk without an edge; internal toggling resumes 10 clk later.
- SYNC_EN, ext_tod period 30 clk -> never locks, and tod_o stays internal at period 20.

Source files
------------

// File: rtl/cia_pkg.sv
// cia_pkg: shared types, constants and helpers for the CIA TOD generator.
// Used by cia_phase_acc and cia_todgen.
package cia_pkg;

    // Sync state machine: internal generator, acquiring lock, locked to ext_tod.
    typedef enum logic [1:0] {
        ST_INT = 2'd0,
        ST_ACQ = 2'd1,
        ST_EXT = 2'd2
    } todgen_state_t;

    localparam int TOD_HZ_50 = 50;
    localparam int TOD_HZ_60 = 60;

    // Phase step per clk: twice the mains rate, because the wave toggles twice per period.
    function automatic int tod_inc(input logic sel60);
        return sel60 ? 2 * TOD_HZ_60 : 2 * TOD_HZ_50;
    endfunction

    // Nominal mains period in clk cycles.
    function automatic int tod_period(input int clk_hz, input logic sel60);
        return clk_hz / (sel60 ? TOD_HZ_60 : TOD_HZ_50);
    endfunction

endpackage

// File: rtl/cia_phase_acc.sv
// cia_phase_acc: phase accumulator that emits a toggle strobe each time the
// running phase crosses CLK_HZ. Wrapping by subtraction keeps the long-term
// toggle rate exact for any increment.
module cia_phase_acc #(
    parameter int  CLK_HZ = 24000000,
    localparam int ACC_W  = $clog2(CLK_HZ) + 1
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             en,
    input  logic             clr,
    input  logic [ACC_W-1:0] inc,
    output logic             toggle
);

    localparam logic [ACC_W-1:0] LIMIT = ACC_W'(CLK_HZ);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;

    // acc < CLK_HZ and inc is small, so the sum never overflows ACC_W bits.
    assign sum    = acc + inc;
    assign toggle = en && !clr && (sum >= LIMIT);

    // Accumulate while enabled, wrap by CLK_HZ on a toggle; clr restarts the phase at 0.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!res_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= toggle ? sum - LIMIT : sum;
        end
    end

endmodule

// File: rtl/cia_todgen.sv
// cia_todgen: 50/60 Hz TOD square-wave generator for the CIA TOD pin.
// Optional feature macro CIA_TODGEN_SYNC_EN: lock tod_o to an external
// mains-derived wave (ext_tod) once LOCK_EDGES consecutive in-window edges
// have been seen; fall back to the internal generator on timeout.
module cia_todgen
    import cia_pkg::*;
#(
    parameter int CLK_HZ     = 24000000,
    parameter int LOCK_EDGES = 4
) (
    input  logic clk,
    input  logic res_n,
    input  logic en,
    input  logic sel60,
    input  logic ext_tod,
    output logic tod_o,
    output logic tick,
    output logic ext_lock
);

    localparam int ACC_W = $clog2(CLK_HZ) + 1;

    logic [ACC_W-1:0] inc;
    logic             acc_toggle;
    logic             acc_clr;
    logic             src_ext;
    logic             ext_lvl;

    // sel60 feeds the increment directly, so a rate change applies on the next add.
    assign inc = ACC_W'(tod_inc(sel60));

    cia_phase_acc #(
        .CLK_HZ (CLK_HZ)
    ) u_phase_acc (
        .clk    (clk),
        .res_n  (res_n),
        .en     (en),
        .clr    (acc_clr),
        .inc    (inc),
        .toggle (acc_toggle)
    );

`ifdef CIA_TODGEN_SYNC_EN
    localparam int P60   = tod_period(CLK_HZ, 1'b1);
    localparam int P50   = tod_period(CLK_HZ, 1'b0);
    localparam int CNT_W = $clog2((5 * P50) / 2 + 2) + 1;
    localparam int LCK_W = $clog2(LOCK_EDGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             ext_ff1, ext_ff2, ext_ff3;
    logic             ext_edge;
    todgen_state_t    state, state_nxt;
    logic [LCK_W-1:0] lock_cnt, lock_cnt_nxt, lock_inc;
    logic [CNT_W-1:0] ival_cnt, ival_cnt_nxt;
    logic [CNT_W-1:0] win_lo, win_hi, ext_to;
    logic             in_win;

    // Two-flop synchronizer for ext_tod plus a delay stage for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            ext_ff1 <= 1'b0;
            ext_ff2 <= 1'b0;
            ext_ff3 <= 1'b0;
        end else begin
            ext_ff1 <= ext_tod;
            ext_ff2 <= ext_ff1;
            ext_ff3 <= ext_ff2;
        end
    end

    assign ext_edge = ext_ff2 & ~ext_ff3;

    // ival_cnt reads (cycles since last edge - 1) at the next edge, hence the -1 on
    // the window bounds. Window is P +/- 12.5%, rounded inward.
    assign win_lo = sel60 ? CNT_W'((7 * P60 + 7) / 8 - 1) : CNT_W'((7 * P50 + 7) / 8 - 1);
    assign win_hi = sel60 ? CNT_W'((9 * P60) / 8 - 1)     : CNT_W'((9 * P50) / 8 - 1);
    assign ext_to = sel60 ? CNT_W'((5 * P60) / 2)         : CNT_W'((5 * P50) / 2);

    assign in_win   = (ival_cnt >= win_lo) && (ival_cnt <= win_hi);
    assign lock_inc = lock_cnt + LCK_W'(1);

    // Sync FSM next-state: edge qualification, lock counting and timeouts.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        ival_cnt_nxt = (ival_cnt == CNT_MAX) ? ival_cnt : ival_cnt + CNT_W'(1);
        acc_clr      = 1'b0;
        if (!en) begin
            state_nxt    = ST_INT;
            lock_cnt_nxt = '0;
            ival_cnt_nxt = '0;
        end else begin
            case (state)
                ST_INT: begin
                    if (ext_edge) begin
                        state_nxt    = ST_ACQ;
                        lock_cnt_nxt = '0;
                        ival_cnt_nxt = '0;
                    end
                end
                ST_ACQ: begin
                    if (ext_edge) begin
                        ival_cnt_nxt = '0;
                        if (!in_win) begin
                            lock_cnt_nxt = '0;
                        end else begin
                            lock_cnt_nxt = lock_inc;
                            if (lock_inc == LCK_W'(LOCK_EDGES)) state_nxt = ST_EXT;
                        end
                    end else if (ival_cnt > win_hi) begin
                        state_nxt    = ST_INT;
                        lock_cnt_nxt = '0;
                    end
                end
                ST_EXT: begin
                    // Off-window edges keep the lock; only a missing edge drops it.
                    if (ext_edge) begin
                        ival_cnt_nxt = '0;
                    end else if (ival_cnt > ext_to) begin
                        state_nxt    = ST_INT;
                        lock_cnt_nxt = '0;
                        acc_clr      = 1'b1;
                    end
                end
                default: begin
                    state_nxt    = ST_INT;
                    lock_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Sync FSM state register.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            state    <= ST_INT;
            lock_cnt <= '0;
            ival_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            ival_cnt <= ival_cnt_nxt;
        end
    end

    // tod_o loads ext_ff1 in EXT, acting as a parallel second synchronizer stage:
    // this gives the 2-clk input-to-output latency with tod_o still registered.
    assign src_ext = (state == ST_EXT);
    assign ext_lvl = ext_ff1;
`else
    logic unused_sync;

    assign src_ext     = 1'b0;
    assign ext_lvl     = 1'b0;
    assign acc_clr     = 1'b0;
    assign unused_sync = ext_tod | (LOCK_EDGES < 0);
`endif

    assign ext_lock = src_ext;

    // Output register: internal wave in INT/ACQ, external wave when locked; tick on 0->1 only.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            tod_o <= 1'b0;
            tick  <= 1'b0;
        end else if (!en) begin
            tick  <= 1'b0;
        end else if (src_ext) begin
            tod_o <= ext_lvl;
            tick  <= ext_lvl & ~tod_o;
        end else begin
            tod_o <= tod_o ^ acc_toggle;
            tick  <= acc_toggle & ~tod_o;
        end
    end

endmodule

// File: tb/tb_cia_todgen.sv
// tb_cia_todgen: self-checking bench for cia_todgen at CLK_HZ=1200.
// Sync scenarios are built only when CIA_TODGEN_SYNC_EN is defined.
module tb_cia_todgen;

    localparam int CLK_HZ     = 1200;
    localparam int LOCK_EDGES = 4;

    logic clk = 1'b0;
    logic res_n, en, sel60, ext_tod;
    logic tod_o, tick, ext_lock;

    int checks = 0;
    int errors = 0;

    // Reference model: total phase ever added; the wave level is the parity of
    // how many whole CLK_HZ units have been crossed.
    longint phase_total = 0;
    bit     exp_tod     = 1'b0;
    bit     exp_tick    = 1'b0;

    cia_todgen #(
        .CLK_HZ     (CLK_HZ),
        .LOCK_EDGES (LOCK_EDGES)
    ) dut (
        .clk      (clk),
        .res_n    (res_n),
        .en       (en),
        .sel60    (sel60),
        .ext_tod  (ext_tod),
        .tod_o    (tod_o),
        .tick     (tick),
        .ext_lock (ext_lock)
    );

    always #5 clk = ~clk;

    // One clk: update the model with the inputs seen at the edge, then sample 1 time unit later.
    task automatic step();
        bit prev;
        @(posedge clk);
        if (!res_n) begin
            phase_total = 0;
            exp_tod     = 1'b0;
            exp_tick    = 1'b0;
        end else if (en) begin
            prev        = exp_tod;
            phase_total = phase_total + (sel60 ? 120 : 100);
            exp_tod     = ((phase_total / CLK_HZ) % 2) == 1;
            exp_tick    = !prev && exp_tod;
        end else begin
            exp_tick    = 1'b0;
        end
        #1;
    endtask

    // Step until tod_o changes; n = steps taken, or -1 if the budget runs out.
    task automatic wait_toggle(input int budget, output int n);
        logic start;
        start = tod_o;
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (tod_o !== start) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic reset_dut();
        res_n = 1'b0; en = 1'b0; sel60 = 1'b1; ext_tod = 1'b0;
        step();
        step();
        res_n = 1'b1;
    endtask

    task automatic test_reset();
        res_n = 1'b0; en = 1'b1; sel60 = 1'b1; ext_tod = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (tod_o !== 1'b0 || tick !== 1'b0 || ext_lock !== 1'b0) begin
                errors++;
                $display("FAIL reset: tod_o=%b tick=%b ext_lock=%b, expected all 0", tod_o, tick, ext_lock);
            end
        end
        // Released but disabled: everything holds at 0.
        res_n = 1'b1; en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if (tod_o !== 1'b0 || tick !== 1'b0) begin
                errors++;
                $display("FAIL en_low_hold: tod_o=%b tick=%b, expected 0 0", tod_o, tick);
            end
        end
    endtask

    task automatic test_rate60();
        int last = 0;
        int ticks = 0;
        logic prev;
        reset_dut();
        en = 1'b1; sel60 = 1'b1;
        prev = tod_o;
        for (int i = 1; i <= 2000; i++) begin
            step();
            checks++;
            if (tod_o !== exp_tod || tick !== exp_tick) begin
                errors++;
                $display("FAIL model60 cyc %0d: tod_o=%b tick=%b, expected %b %b", i, tod_o, tick, exp_tod, exp_tick);
            end
            if (tick === 1'b1) ticks++;
            if (tod_o !== prev) begin
                checks++;
                if (i - last != 10) begin
                    errors++;
                    $display("FAIL spacing60 cyc %0d: gap %0d, expected 10", i, i - last);
                end
                last = i;
                prev = tod_o;
            end
        end
        checks++;
        if (ticks != 100) begin
            errors++;
            $display("FAIL ticks60: %0d ticks, expected 100", ticks);
        end
    endtask

    task automatic test_rate50_switch();
        int n;
        reset_dut();
        en = 1'b1; sel60 = 1'b1;
        wait_toggle(40, n);
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL first60: %0d clk, expected 10", n);
        end
        // 5 clk into the high half (phase 600), switch to 50 Hz: 6 more adds of 100 reach 1200.
        for (int k = 0; k < 5; k++) step();
        sel60 = 1'b0;
        wait_toggle(40, n);
        checks++;
        if (n != 6 || tod_o !== 1'b0) begin
            errors++;
            $display("FAIL switch_gap: %0d clk tod_o=%b, expected 6 clk tod_o=0", n, tod_o);
        end
        for (int k = 0; k < 2; k++) begin
            wait_toggle(40, n);
            checks++;
            if (n != 12) begin
                errors++;
                $display("FAIL spacing50: %0d clk, expected 12", n);
            end
        end
        // Random rate switching against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) sel60 = ~sel60;
            step();
            checks++;
            if (tod_o !== exp_tod || tick !== exp_tick) begin
                errors++;
                $display("FAIL model_sw cyc %0d: tod_o=%b tick=%b, expected %b %b", i, tod_o, tick, exp_tod, exp_tick);
            end
        end
    endtask

    task automatic test_enable();
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 31) == 0) sel60 = ~sel60;
            step();
            checks++;
            if (tod_o !== exp_tod || tick !== exp_tick) begin
                errors++;
                $display("FAIL model_en cyc %0d: tod_o=%b tick=%b, expected %b %b", i, tod_o, tick, exp_tod, exp_tick);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        en = 1'b1; sel60 = 1'b1;
        for (int k = 0; k < 3 && tod_o !== 1'b1; k++) wait_toggle(40, n);
        for (int k = 0; k < 3; k++) step();
        checks++;
        if (tod_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_high: tod_o=%b, expected 1", tod_o);
        end
        res_n = 1'b0;
        step();
        checks++;
        if (tod_o !== 1'b0 || tick !== 1'b0 || ext_lock !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: tod_o=%b tick=%b ext_lock=%b, expected all 0", tod_o, tick, ext_lock);
        end
        res_n = 1'b1;
        wait_toggle(40, n);
        checks++;
        if (n != 10 || tick !== 1'b1) begin
            errors++;
            $display("FAIL restart: first toggle after %0d clk tick=%b, expected 10 clk tick=1", n, tick);
        end
    endtask

    // ext_tod that must never lock: period 30 when sync is built, random noise otherwise.
    task automatic test_ext_nolock();
        int off;
        reset_dut();
        en = 1'b1; sel60 = 1'b1;
        off = int'($urandom_range(0, 29));
        for (int i = 0; i < 400; i++) begin
`ifdef CIA_TODGEN_SYNC_EN
            ext_tod = (((i + off) % 30) < 15);
`else
            ext_tod = $urandom_range(0, 1) == 1;
`endif
            step();
            checks++;
            if (tod_o !== exp_tod || tick !== exp_tick || ext_lock !== 1'b0) begin
                errors++;
                $display("FAIL nolock cyc %0d: tod_o=%b tick=%b ext_lock=%b, expected %b %b 0",
                         i, tod_o, tick, ext_lock, exp_tod, exp_tick);
            end
        end
        ext_tod = 1'b0;
    endtask

`ifdef CIA_TODGEN_SYNC_EN
    // Period-20 ext_tod (rises at steps 0,20,...,180), then stuck low from step 200.
    task automatic test_lock_track_timeout();
        bit   hist  [300];
        logic lock_s[300];
        logic tod_s [300];
        logic tick_s[300];
        int   lock_i = -1;
        int   fall_i = -1;
        int   tog_i  = -1;
        reset_dut();
        en = 1'b1; sel60 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ext_tod   = (i < 200) && ((i % 20) < 10);
            hist[i]   = ext_tod;
            step();
            lock_s[i] = ext_lock;
            tod_s[i]  = tod_o;
            tick_s[i] = tick;
        end
        ext_tod = 1'b0;
        for (int i = 0; i < 300; i++) if (lock_i < 0 && lock_s[i] === 1'b1) lock_i = i;
        // 4th in-window rise is at step 80; allow the synchronizer and edge detector delay.
        checks++;
        if (!(lock_i > 80 && lock_i <= 84)) begin
            errors++;
            $display("FAIL lock_time: ext_lock rose at step %0d, expected in 81..84", lock_i);
        end
        if (lock_i > 0 && lock_i < 190) begin
            for (int i = lock_i + 1; i < 200; i++) begin
                checks++;
                if (tod_s[i] !== hist[i-1] || lock_s[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL track step %0d: tod_o=%b ext_lock=%b, expected %b 1", i, tod_s[i], lock_s[i], hist[i-1]);
                end
                if (i >= lock_i + 2) begin
                    checks++;
                    if (tick_s[i] !== (hist[i-1] & ~hist[i-2])) begin
                        errors++;
                        $display("FAIL track_tick step %0d: tick=%b, expected %b", i, tick_s[i], hist[i-1] & ~hist[i-2]);
                    end
                end
            end
            for (int i = lock_i + 1; i < 300; i++) if (fall_i < 0 && lock_s[i] !== 1'b1) fall_i = i;
        end
        // Last rise at step 180: lock must survive 50 clk of silence and drop shortly after.
        checks++;
        if (!(fall_i > 230 && fall_i <= 240)) begin
            errors++;
            $display("FAIL timeout: ext_lock fell at step %0d, expected in 231..240", fall_i);
        end
        if (fall_i > 0 && fall_i < 290) begin
            checks++;
            if (tod_s[fall_i] !== 1'b0) begin
                errors++;
                $display("FAIL hold_at_switch: tod_o=%b, expected 0", tod_s[fall_i]);
            end
            for (int j = fall_i + 1; j < 300; j++) if (tog_i < 0 && tod_s[j] !== tod_s[fall_i]) tog_i = j;
            checks++;
            if (tog_i < 0 || tog_i - fall_i != 10 || tick_s[tog_i] !== 1'b1) begin
                errors++;
                $display("FAIL resume: first internal toggle %0d clk after unlock, expected 10 with tick", tog_i - fall_i);
            end
        end
    endtask
`endif

    initial begin
        res_n = 1'b0; en = 1'b0; sel60 = 1'b1; ext_tod = 1'b0;
        test_reset();
        test_rate60();
        test_rate50_switch();
        test_enable();
        test_reset_mid();
        test_ext_nolock();
`ifdef CIA_TODGEN_SYNC_EN
        test_lock_track_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
